// File: rtl/fp_div_pkg.sv
// Shared types, flag positions and operand classification helpers for the iterative FP divider.
package fp_div_pkg;

    localparam int MAX_W = 64;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_UNPACK = 3'd1,
        ST_DIVIDE = 3'd2,
        ST_NORM   = 3'd3,
        ST_ROUND  = 3'd4,
        ST_OUT    = 3'd5
    } state_e;

    localparam int FLG_INV = 3;
    localparam int FLG_DBZ = 2;
    localparam int FLG_OVF = 1;
    localparam int FLG_UDF = 0;

    function automatic logic [MAX_W-1:0] ones_mask(input int ew);
        return (64'd1 << ew) - 64'd1;
    endfunction

    function automatic logic is_zero(input logic [MAX_W-1:0] e);
        return e == {MAX_W{1'b0}};
    endfunction

    function automatic logic is_inf(input logic [MAX_W-1:0] e, input logic [MAX_W-1:0] m, input int ew);
        return (e == ones_mask(ew)) && (m == {MAX_W{1'b0}});
    endfunction

    function automatic logic is_nan(input logic [MAX_W-1:0] e, input logic [MAX_W-1:0] m, input int ew);
        return (e == ones_mask(ew)) && (m != {MAX_W{1'b0}});
    endfunction

    // Quiet NaN: sign 0, exponent all ones, mantissa MSB set.
    function automatic logic [MAX_W-1:0] qnan(input int ew, input int mw);
        logic [MAX_W-1:0] v;
        v = ones_mask(ew) << mw;
        v = v | (64'd1 << (mw - 1));
        return v;
    endfunction

endpackage

// File: rtl/fp_div_mant_core.sv
// Restoring mantissa divider: one quotient bit per cycle for MAN_W+3 cycles.
module fp_div_mant_core
    import fp_div_pkg::*;
#(
    parameter int MAN_W = 23
) (
    input  logic             sys_clk,
    input  logic             sys_rst,
    input  logic             start,
    input  logic [MAN_W-1:0] man_a,
    input  logic [MAN_W-1:0] man_b,
    output logic             done,
    output logic [MAN_W+2:0] quot,
    output logic             sticky
);

    localparam int STEPS = MAN_W + 3;
    localparam int CNT_W = $clog2(STEPS + 1);

    logic [MAN_W+1:0] rem_r;
    logic [MAN_W+1:0] div_r;
    logic [MAN_W+2:0] q_r;
    logic [CNT_W-1:0] cnt_r;
    logic             busy_r;
    logic             rem_ge_s;
    logic [MAN_W+1:0] rem_sel_s;

    // Trial subtraction for the current step.
    always_comb begin
        rem_ge_s  = (rem_r >= div_r);
        rem_sel_s = rem_r;
        if (rem_ge_s) begin
            rem_sel_s = rem_r - div_r;
        end else begin
            rem_sel_s = rem_r;
        end
    end

    // Remainder, quotient and step counter.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            rem_r  <= {(MAN_W+2){1'b0}};
            div_r  <= {(MAN_W+2){1'b0}};
            q_r    <= {(MAN_W+3){1'b0}};
            cnt_r  <= {CNT_W{1'b0}};
            busy_r <= 1'b0;
        end else if (start) begin
            rem_r  <= {1'b0, 1'b1, man_a};
            div_r  <= {1'b0, 1'b1, man_b};
            q_r    <= {(MAN_W+3){1'b0}};
            cnt_r  <= CNT_W'(STEPS);
            busy_r <= 1'b1;
        end else if (busy_r) begin
            q_r    <= {q_r[MAN_W+1:0], rem_ge_s};
            rem_r  <= rem_sel_s << 1;
            cnt_r  <= cnt_r - CNT_W'(1);
            busy_r <= (cnt_r != CNT_W'(1));
        end else begin
            busy_r <= 1'b0;
        end
    end

    // done marks the edge that performs the final step.
    assign done   = busy_r && (cnt_r == CNT_W'(1));
    assign quot   = q_r;
    assign sticky = (rem_r != {(MAN_W+2){1'b0}});

endmodule

// File: rtl/fp_div_iter.sv
// Iterative IEEE754-style divider: special-case resolution, restoring mantissa divide,
// normalisation and round-to-nearest-even, one operation in flight.
module fp_div_iter
    import fp_div_pkg::*;
#(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic                       sys_clk,
    input  logic                       sys_rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [1+EXP_W+MAN_W-1:0]   data1_in,
    input  logic [1+EXP_W+MAN_W-1:0]   data2_in,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [1+EXP_W+MAN_W-1:0]   data_out,
    output logic [3:0]                 flags
);

    localparam int W    = 1 + EXP_W + MAN_W;
    localparam int BIAS = (1 << (EXP_W - 1)) - 1;
    localparam int EW   = EXP_W + 2;
    localparam logic [MAX_W-1:0]     QNAN_FULL = qnan(EXP_W, MAN_W);
    localparam logic [W-1:0]         QNAN      = QNAN_FULL[W-1:0];
    localparam logic signed [EW-1:0] EXP_MAX   = EW'((1 << EXP_W) - 1);
    localparam logic signed [EW-1:0] EXP_ZERO  = {EW{1'b0}};

    state_e                state_r;
    logic                  s1_r, s2_r, sign_r;
    logic [EXP_W-1:0]      e1_r, e2_r;
    logic [MAN_W-1:0]      m1_r, m2_r;
    logic signed [EW-1:0]  exp_r;
    logic [MAN_W+1:0]      frac_r;
    logic                  sticky_r;

    logic                  nan1_s, nan2_s, inf1_s, inf2_s, zero1_s, zero2_s;
    logic                  sgn_s, spec_s;
    logic [W-1:0]          spec_data_s;
    logic [3:0]            spec_flags_s;
    logic                  core_start_s, core_done_s, core_sticky_s;
    logic [MAN_W+2:0]      core_q_s;

    logic                  round_up_s, carry_s;
    logic [MAN_W:0]        mant_sum_s;
    logic signed [EW-1:0]  exp_rnd_s;
    logic [W-1:0]          rnd_data_s;
    logic [3:0]            rnd_flags_s;

    // Operand classification and special-result selection, highest priority first.
    always_comb begin
        nan1_s       = is_nan(MAX_W'(e1_r), MAX_W'(m1_r), EXP_W);
        nan2_s       = is_nan(MAX_W'(e2_r), MAX_W'(m2_r), EXP_W);
        inf1_s       = is_inf(MAX_W'(e1_r), MAX_W'(m1_r), EXP_W);
        inf2_s       = is_inf(MAX_W'(e2_r), MAX_W'(m2_r), EXP_W);
        zero1_s      = is_zero(MAX_W'(e1_r));
        zero2_s      = is_zero(MAX_W'(e2_r));
        sgn_s        = s1_r ^ s2_r;
        spec_s       = 1'b1;
        spec_data_s  = {W{1'b0}};
        spec_flags_s = 4'b0000;
        if (nan1_s || nan2_s) begin
            spec_data_s = QNAN;
        end else if ((zero1_s && zero2_s) || (inf1_s && inf2_s)) begin
            spec_data_s           = QNAN;
            spec_flags_s[FLG_INV] = 1'b1;
        end else if (inf1_s) begin
            spec_data_s = {sgn_s, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        end else if (inf2_s || zero1_s) begin
            spec_data_s = {sgn_s, {(W-1){1'b0}}};
        end else if (zero2_s) begin
            spec_data_s           = {sgn_s, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            spec_flags_s[FLG_DBZ] = 1'b1;
        end else begin
            spec_s = 1'b0;
        end
    end

    // Round to nearest even, then range check the final exponent.
    always_comb begin
        round_up_s  = frac_r[1] & (frac_r[0] | sticky_r | frac_r[2]);
        mant_sum_s  = {1'b0, frac_r[MAN_W+1:2]} + (MAN_W+1)'(round_up_s);
        carry_s     = mant_sum_s[MAN_W];
        exp_rnd_s   = exp_r + EW'(carry_s);
        rnd_flags_s = 4'b0000;
        if (exp_rnd_s >= EXP_MAX) begin
            rnd_data_s           = {sign_r, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            rnd_flags_s[FLG_OVF] = 1'b1;
        end else if (exp_rnd_s <= EXP_ZERO) begin
            rnd_data_s           = {sign_r, {(W-1){1'b0}}};
            rnd_flags_s[FLG_UDF] = 1'b1;
        end else if (carry_s) begin
            rnd_data_s = {sign_r, exp_rnd_s[EXP_W-1:0], {MAN_W{1'b0}}};
        end else begin
            rnd_data_s = {sign_r, exp_rnd_s[EXP_W-1:0], mant_sum_s[MAN_W-1:0]};
        end
    end

    assign core_start_s = (state_r == ST_UNPACK) && !spec_s;

    fp_div_mant_core #(
        .MAN_W (MAN_W)
    ) u_core (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .start   (core_start_s),
        .man_a   (m1_r),
        .man_b   (m2_r),
        .done    (core_done_s),
        .quot    (core_q_s),
        .sticky  (core_sticky_s)
    );

    // Control FSM with registered handshake and result outputs.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_r   <= ST_IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            data_out  <= {W{1'b0}};
            flags     <= 4'b0000;
            s1_r      <= 1'b0;
            s2_r      <= 1'b0;
            sign_r    <= 1'b0;
            e1_r      <= {EXP_W{1'b0}};
            e2_r      <= {EXP_W{1'b0}};
            m1_r      <= {MAN_W{1'b0}};
            m2_r      <= {MAN_W{1'b0}};
            exp_r     <= {EW{1'b0}};
            frac_r    <= {(MAN_W+2){1'b0}};
            sticky_r  <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (in_valid && in_ready) begin
                        {s1_r, e1_r, m1_r} <= data1_in;
                        {s2_r, e2_r, m2_r} <= data2_in;
                        in_ready           <= 1'b0;
                        state_r            <= ST_UNPACK;
                    end else begin
                        in_ready <= 1'b1;
                    end
                end
                ST_UNPACK: begin
                    exp_r  <= EW'(e1_r) - EW'(e2_r) + EW'(BIAS);
                    sign_r <= sgn_s;
                    if (spec_s) begin
                        data_out  <= spec_data_s;
                        flags     <= spec_flags_s;
                        out_valid <= 1'b1;
                        state_r   <= ST_OUT;
                    end else begin
                        state_r <= ST_DIVIDE;
                    end
                end
                ST_DIVIDE: begin
                    if (core_done_s) begin
                        state_r <= ST_NORM;
                    end else begin
                        state_r <= ST_DIVIDE;
                    end
                end
                ST_NORM: begin
                    // Drop the hidden bit; a quotient below 1.0 needs one left shift.
                    sticky_r <= core_sticky_s;
                    if (!core_q_s[MAN_W+2]) begin
                        frac_r <= {core_q_s[MAN_W:0], 1'b0};
                        exp_r  <= exp_r - EW'(1);
                    end else begin
                        frac_r <= core_q_s[MAN_W+1:0];
                    end
                    state_r <= ST_ROUND;
                end
                ST_ROUND: begin
                    data_out  <= rnd_data_s;
                    flags     <= rnd_flags_s;
                    out_valid <= 1'b1;
                    state_r   <= ST_OUT;
                end
                ST_OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state_r   <= ST_IDLE;
                    end else begin
                        out_valid <= 1'b1;
                    end
                end
                default: begin
                    state_r   <= ST_IDLE;
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fp_div_iter.sv
// Directed-vector bench for fp_div_iter: single precision table plus hold, reset and half-precision sequences.
module tb_fp_div_iter;

    logic        sys_clk = 1'b0;
    logic        sys_rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] data1_in = 32'h0;
    logic [31:0] data2_in = 32'h0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] data_out;
    logic [3:0]  flags;

    logic        h_in_valid = 1'b0;
    logic        h_in_ready;
    logic [15:0] h_data1_in = 16'h0;
    logic [15:0] h_data2_in = 16'h0;
    logic        h_out_valid;
    logic        h_out_ready = 1'b0;
    logic [15:0] h_data_out;
    logic [3:0]  h_flags;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] q;
        logic [3:0]  f;
        int          lat;
    } vec_t;

    vec_t vecs[15];

    always #5 sys_clk = ~sys_clk;

    fp_div_iter dut (
        .sys_clk   (sys_clk),
        .sys_rst   (sys_rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .data1_in  (data1_in),
        .data2_in  (data2_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .data_out  (data_out),
        .flags     (flags)
    );

    fp_div_iter #(.EXP_W(5), .MAN_W(10)) dut_h (
        .sys_clk   (sys_clk),
        .sys_rst   (sys_rst),
        .in_valid  (h_in_valid),
        .in_ready  (h_in_ready),
        .data1_in  (h_data1_in),
        .data2_in  (h_data2_in),
        .out_valid (h_out_valid),
        .out_ready (h_out_ready),
        .data_out  (h_data_out),
        .flags     (h_flags)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Latency counts edges from the accept edge (inclusive) to the first edge leaving out_valid high.
    task automatic run_op(input int idx, input vec_t v);
        int lat;
        @(negedge sys_clk);
        check($sformatf("v%0d_in_ready", idx), 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        data1_in = v.a;
        data2_in = v.b;
        @(posedge sys_clk);
        lat = 1;
        @(negedge sys_clk);
        in_valid = 1'b0;
        while (!out_valid && lat < 200) begin
            @(posedge sys_clk);
            lat++;
            @(negedge sys_clk);
        end
        check($sformatf("v%0d_data", idx), data_out, v.q);
        check($sformatf("v%0d_flags", idx), 32'(flags), 32'(v.f));
        check($sformatf("v%0d_latency", idx), 32'(lat), 32'(v.lat));
        out_ready = 1'b1;
        @(posedge sys_clk);
        @(negedge sys_clk);
        out_ready = 1'b0;
        check($sformatf("v%0d_valid_drop", idx), 32'(out_valid), 32'd0);
    endtask

    initial begin
        int lat;
        vecs[0]  = '{32'h40C00000, 32'h40000000, 32'h40400000, 4'h0, 30};
        vecs[1]  = '{32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 4'h0, 30};
        vecs[2]  = '{32'h3F800000, 32'h80000000, 32'hFF800000, 4'h4, 2};
        vecs[3]  = '{32'h00000000, 32'h00000000, 32'h7FC00000, 4'h8, 2};
        vecs[4]  = '{32'h7F000000, 32'h3E800000, 32'h7F800000, 4'h2, 30};
        vecs[5]  = '{32'h00800000, 32'h4B000000, 32'h00000000, 4'h1, 30};
        vecs[6]  = '{32'h7F800001, 32'h00000000, 32'h7FC00000, 4'h0, 2};
        vecs[7]  = '{32'h7F800000, 32'hFF800000, 32'h7FC00000, 4'h8, 2};
        vecs[8]  = '{32'h7F800000, 32'hC0000000, 32'hFF800000, 4'h0, 2};
        vecs[9]  = '{32'hC0400000, 32'h7F800000, 32'h80000000, 4'h0, 2};
        vecs[10] = '{32'h80000000, 32'h40A00000, 32'h80000000, 4'h0, 2};
        vecs[11] = '{32'h00000001, 32'h3F800000, 32'h00000000, 4'h0, 2};
        vecs[12] = '{32'hC0490FDB, 32'h40490FDB, 32'hBF800000, 4'h0, 30};
        vecs[13] = '{32'h40000000, 32'h3F000000, 32'h40800000, 4'h0, 30};
        vecs[14] = '{32'h3F800000, 32'h3F800001, 32'h3F7FFFFE, 4'h0, 30};

        // Reset state
        repeat (2) @(posedge sys_clk);
        @(negedge sys_clk);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_data_out", data_out, 32'h0);
        check("rst_flags", 32'(flags), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        sys_rst = 1'b0;

        for (int i = 0; i < 15; i++) begin
            run_op(i, vecs[i]);
        end

        // Output held under back-pressure; new operands ignored while in OUT
        @(negedge sys_clk);
        in_valid = 1'b1;
        data1_in = 32'h40C00000;
        data2_in = 32'h40000000;
        @(posedge sys_clk);
        @(negedge sys_clk);
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 200) begin
            @(posedge sys_clk);
            lat++;
            @(negedge sys_clk);
        end
        check("hold_latency", 32'(lat), 32'd30);
        for (int k = 0; k < 5; k++) begin
            in_valid = 1'b1;
            data1_in = 32'h3F800000;
            data2_in = 32'h40400000;
            check($sformatf("hold%0d_data", k), data_out, 32'h40400000);
            check($sformatf("hold%0d_flags", k), 32'(flags), 32'd0);
            check($sformatf("hold%0d_valid", k), 32'(out_valid), 32'd1);
            check($sformatf("hold%0d_in_ready", k), 32'(in_ready), 32'd0);
            @(posedge sys_clk);
            @(negedge sys_clk);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge sys_clk);
        @(negedge sys_clk);
        out_ready = 1'b0;
        check("hold_release_valid", 32'(out_valid), 32'd0);
        check("hold_release_in_ready", 32'(in_ready), 32'd1);

        // Reset in the middle of DIVIDE
        @(negedge sys_clk);
        in_valid = 1'b1;
        data1_in = 32'h3F800000;
        data2_in = 32'h40400000;
        @(posedge sys_clk);
        @(negedge sys_clk);
        in_valid = 1'b0;
        repeat (8) @(posedge sys_clk);
        @(negedge sys_clk);
        sys_rst = 1'b1;
        @(posedge sys_clk);
        @(negedge sys_clk);
        sys_rst = 1'b0;
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_in_ready", 32'(in_ready), 32'd1);
        check("midrst_data_out", data_out, 32'h0);
        run_op(100, vecs[0]);
        run_op(101, vecs[1]);

        // Half-precision build
        @(negedge sys_clk);
        h_in_valid = 1'b1;
        h_data1_in = 16'h4600;
        h_data2_in = 16'h4000;
        @(posedge sys_clk);
        lat = 1;
        @(negedge sys_clk);
        h_in_valid = 1'b0;
        while (!h_out_valid && lat < 200) begin
            @(posedge sys_clk);
            lat++;
            @(negedge sys_clk);
        end
        check("half_data", 32'(h_data_out), 32'h4200);
        check("half_flags", 32'(h_flags), 32'd0);
        check("half_latency", 32'(lat), 32'd17);
        h_out_ready = 1'b1;
        @(posedge sys_clk);
        @(negedge sys_clk);
        h_out_ready = 1'b0;
        check("half_valid_drop", 32'(h_out_valid), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
